// File: rtl/irq_controller.sv
// irq_controller: NIRQ-channel fixed-priority interrupt front end for the ExtIRQ/ExcAck/ERet handshake; IRQC_SYNC_EN adds a 2-flop input synchroniser.
// irq_in->ExtIRQ 2 cycles (4 with IRQC_SYNC_EN); a request is held until ExcAck, new events accumulate in pending meanwhile.
module irq_controller #(
  parameter int              NIRQ       = 4,
  parameter logic [NIRQ-1:0] EDGE_MODE  = '1,
  parameter logic [NIRQ-1:0] MASK_RESET = '1,
  parameter int              IDW        = $clog2(NIRQ)
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wdata,
  input  logic            ExcAck,
  input  logic            ERet,
  output logic            ExtIRQ,
  output logic [IDW-1:0]  irq_id,
  output logic [NIRQ-1:0] ExtlAck,
  output logic [NIRQ-1:0] pending,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} stateT;

  stateT           state, stateNext;
  logic [NIRQ-1:0] irqS, hist, mask, pendNext, active, ackNext;
  logic [IDW-1:0]  winner, idNext;
  logic            reqNext, busyNext, accept;

`ifdef IRQC_SYNC_EN
  logic [NIRQ-1:0] syncA, syncB;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      syncA <= '0;
      syncB <= '0;
    end else begin
      syncA <= irq_in;
      syncB <= syncA;
    end
  end

  assign irqS = syncB;
`else
  assign irqS = irq_in;
`endif

  assign active = pending & mask;
  assign accept = (state == REQ) && ExcAck;

  // Lowest index wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    winner = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (active[i]) winner = IDW'(i);
    end
  end

  // Edge channels: a new rising edge beats a same-cycle acknowledge clear.
  always_comb begin
    pendNext = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (EDGE_MODE[i])
        pendNext[i] = (irqS[i] & ~hist[i]) |
                      (pending[i] & ~(accept && (irq_id == IDW'(i))));
      else
        pendNext[i] = irqS[i];
    end
  end

  always_comb begin
    stateNext = state;
    reqNext   = ExtIRQ;
    idNext    = irq_id;
    busyNext  = busy;
    ackNext   = '0;
    case (state)
      IDLE: begin
        if (|active) begin
          stateNext = REQ;
          reqNext   = 1'b1;
          idNext    = winner;
          busyNext  = 1'b1;
        end
      end
      REQ: begin
        if (ExcAck) begin
          stateNext = SERVICE;
          reqNext   = 1'b0;
          ackNext   = NIRQ'(1) << irq_id;
        end
      end
      SERVICE: begin
        if (ERet) begin
          stateNext = IDLE;
          busyNext  = 1'b0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ExtIRQ  <= 1'b0;
      irq_id  <= '0;
      ExtlAck <= '0;
      busy    <= 1'b0;
      pending <= '0;
      hist    <= '0;
      mask    <= MASK_RESET;
    end else begin
      state   <= stateNext;
      ExtIRQ  <= reqNext;
      irq_id  <= idNext;
      ExtlAck <= ackNext;
      busy    <= busyNext;
      pending <= pendNext;
      hist    <= irqS;
      if (mask_we) mask <= mask_wdata;
    end
  end

endmodule
